bomb_launcher: RTL and testbench
================================

Name: bomb_launcher

Overview:
- Per-player bomb source that drives the stun detector's bomb inputs: bomb X/Y position and the explosion pulse.
- On a drop-button press it latches the player's grid position and runs a fuse countdown. It then emits a one-cycle explosion pulse with the position held stable, and enforces a cooldown before the next drop.
- One instance per player (red, blue). Outputs feed the stun detector and the VGA/HEX fuse display.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per game second.
- FUSE_SEC, 3, fuse length in seconds (legal range 1..7).
- COOLDOWN_SEC, 2, post-blast lockout in seconds (legal range 1..7).
- COORD_W, 6, grid coordinate width.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- drop_btn  in  1  drop request, level, already synchronised to clk
- stunned  in  1  owning player is stunned; drops are refused while high
- player_x  in  COORD_W  current player grid X
- player_y  in  COORD_W  current player grid Y
- bomb_x  out  COORD_W  latched bomb grid X
- bomb_y  out  COORD_W  latched bomb grid Y
- bomb_active  out  1  bomb on the board (ARMED or BLAST)
- bomb_exploded  out  1  one-cycle explosion strobe
- cooldown  out  1  launcher locked out
- fuse_sec_left  out  3  seconds remaining on the fuse, 0 when not ARMED

Behaviour:
- Reset (resetn low, async):
  - state=IDLE; btn_prev=0.
  - bomb_x=bomb_y=0; bomb_active=0; bomb_exploded=0; cooldown=0; fuse_sec_left=0.
  - Both counters cleared.
  - Deassertion is sampled on the next clk rising edge.
- Edge detect:
  - btn_prev<=drop_btn every cycle in every state.
  - drop_edge = drop_btn & ~btn_prev.
  - A button held high through reset release produces no edge until it goes low then high again.
- States: IDLE, ARMED, BLAST, COOLDOWN. All outputs are registered or decoded from the state register only.
- IDLE:
  - On a clock edge with drop_edge=1 and stunned=0: go to ARMED.
  - On that edge: bomb_x<=player_x, bomb_y<=player_y, fuse_sec_left<=FUSE_SEC, tick counter <= TICKS_PER_SEC-1.
  - drop_edge with stunned=1 is discarded, not queued.
- ARMED:
  - bomb_active=1.
  - Tick counter decrements each cycle. At 0 it reloads TICKS_PER_SEC-1 and fuse_sec_left decrements.
  - When fuse_sec_left==1 and tick==0, go to BLAST instead; fuse_sec_left<=0.
  - ARMED lasts exactly FUSE_SEC*TICKS_PER_SEC cycles.
  - drop_edge and stunned are ignored in ARMED.
- BLAST:
  - Exactly one cycle: bomb_exploded=1, bomb_active=1.
  - Next state is COOLDOWN; counters load for COOLDOWN_SEC*TICKS_PER_SEC cycles.
- COOLDOWN:
  - cooldown=1, bomb_active=0.
  - Lasts exactly COOLDOWN_SEC*TICKS_PER_SEC cycles, then IDLE.
  - Presses during COOLDOWN are discarded.
  - An edge on the first IDLE cycle is accepted.
- Position hold: bomb_x/bomb_y change only on an accepted drop. They hold through ARMED, BLAST, COOLDOWN and IDLE until the next accepted drop. This makes the position valid in the cycle bomb_exploded is high.
- Counter widths:
  - Tick counter: ceil(log2(TICKS_PER_SEC)) bits (26 for the default).
  - Seconds counter: 3 bits. No wrap in legal parameter ranges.
- player_x/player_y changes after the drop have no effect on bomb_x/bomb_y.
- Reset mid-operation (any state) returns immediately to IDLE with all outputs at reset values. No bomb_exploded pulse is emitted.

Test Plan (TICKS_PER_SEC=4, FUSE_SEC=3, COOLDOWN_SEC=2):
- Drop edge with player=(10,7), stunned=0 -> next cycle bomb_active=1, bomb=(10,7), fuse_sec_left=3. fuse_sec_left is 2 after 4 cycles and 1 after 8. bomb_exploded high exactly 1 cycle, 12 cycles after ARMED entry. Then cooldown=1 for 8 cycles, then IDLE.
- Move player to (11,8) during ARMED and press again -> bomb stays (10,7), no restart, same explosion cycle.
- Drop edge with stunned=1 -> stays IDLE, bomb_active=0. Release and re-press with stunned=0 -> accepted.
- drop_btn held high continuously across a full cycle of states -> only one bomb. Second drop only after a low-then-high transition.
- Press during the final COOLDOWN cycle -> ignored. Press on the first IDLE cycle -> accepted.
- resetn low during ARMED (fuse_sec_left=2) -> all outputs 0 asynchronously, and no bomb_exploded pulse afterwards.

Source files
------------

// File: rtl/bomb_launcher.sv
// bomb_launcher: one player's bomb source.
// A drop press latches the player's grid position and starts a fuse countdown.
// When the fuse runs out the launcher emits a one-cycle explosion strobe with the
// position still held, then locks out further drops for a cooldown period.
//
// Ports:
//   clk           system clock
//   resetn        asynchronous active-low reset
//   drop_btn      drop request (level, already synchronised to clk)
//   stunned       owning player stunned; drops refused while high
//   player_x/y    current player grid position
//   bomb_x/y      latched bomb position (held until the next accepted drop)
//   bomb_active   bomb on the board (ARMED or BLAST)
//   bomb_exploded one-cycle explosion strobe
//   cooldown      launcher locked out
//   fuse_sec_left seconds left on the fuse, 0 when not ARMED
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for a drop edge while not stunned
// ARMED    | fuse counting down, position latched
// BLAST    | single-cycle explosion strobe
// COOLDOWN | lockout after the blast, presses discarded

module bomb_launcher #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int FUSE_SEC      = 3,
    parameter int COOLDOWN_SEC  = 2,
    parameter int COORD_W       = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               drop_btn,
    input  logic               stunned,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    output logic [COORD_W-1:0] bomb_x,
    output logic [COORD_W-1:0] bomb_y,
    output logic               bomb_active,
    output logic               bomb_exploded,
    output logic               cooldown,
    output logic [2:0]         fuse_sec_left
);

    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
    localparam logic [2:0]        FUSE_LD  = 3'(FUSE_SEC);
    localparam logic [2:0]        COOL_LD  = 3'(COOLDOWN_SEC);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        BLAST    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [2:0]          sec_q, sec_d;
    logic [COORD_W-1:0]  bomb_x_q, bomb_x_d;
    logic [COORD_W-1:0]  bomb_y_q, bomb_y_d;
    logic                btn_prev_q;
    logic                edge_en_q;
    logic                drop_edge;
    logic                last_tick;

    // edge_en_q stays low for the first cycle after reset release so that a
    // button already held through reset is absorbed into btn_prev_q instead of
    // looking like a fresh press.
    assign drop_edge = drop_btn & ~btn_prev_q & edge_en_q;
    assign last_tick = (tick_q == '0) && (sec_q == 3'd1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            sec_q      <= '0;
            bomb_x_q   <= '0;
            bomb_y_q   <= '0;
            btn_prev_q <= 1'b0;
            edge_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            sec_q      <= sec_d;
            bomb_x_q   <= bomb_x_d;
            bomb_y_q   <= bomb_y_d;
            btn_prev_q <= drop_btn;
            edge_en_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        sec_d    = sec_q;
        bomb_x_d = bomb_x_q;
        bomb_y_d = bomb_y_q;

        unique case (state_q)
            IDLE: begin
                if (drop_edge && !stunned) begin
                    state_d  = ARMED;
                    bomb_x_d = player_x;
                    bomb_y_d = player_y;
                    tick_d   = TICK_MAX;
                    sec_d    = FUSE_LD;
                end
            end
            ARMED: begin
                if (last_tick) begin
                    state_d = BLAST;
                    sec_d   = 3'd0;
                end else if (tick_q == '0) begin
                    tick_d = TICK_MAX;
                    sec_d  = sec_q - 3'd1;
                end else begin
                    tick_d = tick_q - TICK_ONE;
                end
            end
            BLAST: begin
                state_d = COOLDOWN;
                tick_d  = TICK_MAX;
                sec_d   = COOL_LD;
            end
            COOLDOWN: begin
                if (last_tick) begin
                    state_d = IDLE;
                    sec_d   = 3'd0;
                end else if (tick_q == '0) begin
                    tick_d = TICK_MAX;
                    sec_d  = sec_q - 3'd1;
                end else begin
                    tick_d = tick_q - TICK_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bomb_x        = bomb_x_q;
    assign bomb_y        = bomb_y_q;
    assign bomb_active   = (state_q == ARMED) || (state_q == BLAST);
    assign bomb_exploded = (state_q == BLAST);
    assign cooldown      = (state_q == COOLDOWN);
    // sec_q is shared with the cooldown timer, so only expose it while ARMED.
    assign fuse_sec_left = (state_q == ARMED) ? sec_q : 3'd0;

endmodule

// File: tb/tb_bomb_launcher.sv
// tb_bomb_launcher: directed stimulus with hand-computed expectations.
// Stimulus pushes each expected explosion (cycle, x, y) into a queue; a monitor
// pops and compares whenever bomb_exploded is seen high.

module tb_bomb_launcher;

    localparam int TPS = 4;
    localparam int FS  = 3;
    localparam int CS  = 2;
    localparam int CW  = 6;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          drop_btn = 1'b1;
    logic          stunned = 1'b0;
    logic [CW-1:0] player_x = '0;
    logic [CW-1:0] player_y = '0;
    logic [CW-1:0] bomb_x;
    logic [CW-1:0] bomb_y;
    logic          bomb_active;
    logic          bomb_exploded;
    logic          cooldown;
    logic [2:0]    fuse_sec_left;

    bomb_launcher #(
        .TICKS_PER_SEC(TPS),
        .FUSE_SEC     (FS),
        .COOLDOWN_SEC (CS),
        .COORD_W      (CW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .drop_btn     (drop_btn),
        .stunned      (stunned),
        .player_x     (player_x),
        .player_y     (player_y),
        .bomb_x       (bomb_x),
        .bomb_y       (bomb_y),
        .bomb_active  (bomb_active),
        .bomb_exploded(bomb_exploded),
        .cooldown     (cooldown),
        .fuse_sec_left(fuse_sec_left)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int x;
        int y;
    } blast_t;

    blast_t exp_q[$];
    blast_t got;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every explosion strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (resetn && bomb_exploded) begin
            chk("blast_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                chk("blast_cycle", cyc, got.cyc);
                chk("blast_x", int'(bomb_x), got.x);
                chk("blast_y", int'(bomb_y), got.y);
                chk("blast_active", int'(bomb_active), 1);
                chk("blast_fuse", int'(fuse_sec_left), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, c, d;

        // Reset state, with the button held high throughout.
        repeat (2) @(negedge clk);
        chk("rst_active", int'(bomb_active), 0);
        chk("rst_exploded", int'(bomb_exploded), 0);
        chk("rst_cooldown", int'(cooldown), 0);
        chk("rst_fuse", int'(fuse_sec_left), 0);
        chk("rst_bomb_x", int'(bomb_x), 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("held_through_reset", int'(bomb_active), 0);

        // First drop at (10,7); button then held through the whole cycle.
        drop_btn = 1'b0;
        @(negedge clk);
        player_x = 6'd10; player_y = 6'd7; drop_btn = 1'b1;
        a = cyc + 1;
        exp_q.push_back('{a + 12, 10, 7});
        to_cyc(a);
        chk("arm_active", int'(bomb_active), 1);
        chk("arm_x", int'(bomb_x), 10);
        chk("arm_y", int'(bomb_y), 7);
        chk("arm_fuse3", int'(fuse_sec_left), 3);
        to_cyc(a + 2);
        player_x = 6'd11; player_y = 6'd8;
        to_cyc(a + 3);
        drop_btn = 1'b0;
        to_cyc(a + 4);
        chk("arm_fuse2", int'(fuse_sec_left), 2);
        drop_btn = 1'b1;
        to_cyc(a + 8);
        chk("arm_fuse1", int'(fuse_sec_left), 1);
        chk("arm_hold_x", int'(bomb_x), 10);
        chk("arm_hold_y", int'(bomb_y), 7);
        to_cyc(a + 11);
        chk("arm_last_active", int'(bomb_active), 1);
        chk("arm_last_exploded", int'(bomb_exploded), 0);
        to_cyc(a + 13);
        chk("cool_start", int'(cooldown), 1);
        chk("cool_inactive", int'(bomb_active), 0);
        chk("cool_fuse", int'(fuse_sec_left), 0);
        chk("cool_hold_x", int'(bomb_x), 10);
        to_cyc(a + 20);
        chk("cool_last", int'(cooldown), 1);
        to_cyc(a + 21);
        chk("idle_after_cool", int'(cooldown), 0);
        to_cyc(a + 25);
        chk("held_one_bomb", int'(bomb_active), 0);
        chk("idle_hold_x", int'(bomb_x), 10);

        // Second drop after low-then-high, at (11,8).
        drop_btn = 1'b0;
        to_cyc(a + 26);
        drop_btn = 1'b1;
        b = a + 27;
        exp_q.push_back('{b + 12, 11, 8});
        to_cyc(b);
        chk("b_active", int'(bomb_active), 1);
        chk("b_x", int'(bomb_x), 11);
        chk("b_fuse3", int'(fuse_sec_left), 3);
        drop_btn = 1'b0;
        // Press sampled on the edge that leaves the final cooldown cycle.
        to_cyc(b + 20);
        chk("b_cool_last", int'(cooldown), 1);
        drop_btn = 1'b1;
        to_cyc(b + 21);
        chk("b_idle", int'(cooldown), 0);
        drop_btn = 1'b0;
        to_cyc(b + 23);
        chk("late_cool_press_ignored", int'(bomb_active), 0);

        // Stunned press is discarded.
        stunned = 1'b1; player_x = 6'd3; player_y = 6'd4; drop_btn = 1'b1;
        to_cyc(b + 25);
        chk("stunned_ignored", int'(bomb_active), 0);
        chk("stunned_hold_x", int'(bomb_x), 11);
        drop_btn = 1'b0;
        to_cyc(b + 26);
        stunned = 1'b0; drop_btn = 1'b1;
        c = b + 27;
        exp_q.push_back('{c + 12, 3, 4});
        to_cyc(c);
        chk("c_active", int'(bomb_active), 1);
        chk("c_x", int'(bomb_x), 3);
        chk("c_y", int'(bomb_y), 4);
        drop_btn = 1'b0;

        // Press on the first IDLE cycle is accepted.
        to_cyc(c + 21);
        chk("c_idle", int'(cooldown), 0);
        chk("c_idle_inactive", int'(bomb_active), 0);
        player_x = 6'd5; player_y = 6'd6; drop_btn = 1'b1;
        d = c + 22;
        to_cyc(d);
        chk("d_active", int'(bomb_active), 1);
        chk("d_x", int'(bomb_x), 5);
        chk("d_fuse3", int'(fuse_sec_left), 3);
        drop_btn = 1'b0;

        // Asynchronous reset mid-fuse; no explosion may follow.
        to_cyc(d + 5);
        chk("d_fuse2", int'(fuse_sec_left), 2);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_active", int'(bomb_active), 0);
        chk("async_rst_exploded", int'(bomb_exploded), 0);
        chk("async_rst_cooldown", int'(cooldown), 0);
        chk("async_rst_fuse", int'(fuse_sec_left), 0);
        chk("async_rst_x", int'(bomb_x), 0);
        chk("async_rst_y", int'(bomb_y), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", int'(bomb_active), 0);
        chk("post_rst_cooldown", int'(cooldown), 0);
        chk("all_blasts_seen", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
